// File: rtl/tile_fifo.sv
// Circular tile buffer between the vector loader and the compute stage.
// The head slot is shown combinationally; each slot also stores a flag marking the last tile of a transfer.
module tile_fifo #(
  parameter int TILE_WIDTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [DATA_WIDTH*ELEM_COUNT-1:0] tile_in,
  input  logic                             tile_valid,
  input  logic                             tile_last,
  output logic [DATA_WIDTH*ELEM_COUNT-1:0] out_tile,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             xfer_done,
  output logic [CNT_W-1:0]                 count,
  output logic                             full,
  output logic                             empty,
  output logic                             overflow
);

  logic [DATA_WIDTH*ELEM_COUNT-1:0] mem [DEPTH];
  logic [DEPTH-1:0]                 last_q;
  logic [PTR_W-1:0]                 wr_ptr;
  logic [PTR_W-1:0]                 rd_ptr;
  logic [CNT_W-1:0]                 count_q;
  logic                             pop;
  logic                             push_ok;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign out_tile  = mem[rd_ptr];
  assign out_last  = last_q[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign push_ok   = tile_valid && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      xfer_done <= 1'b0;
      last_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr]    <= tile_in;
        last_q[wr_ptr] <= tile_last;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push_ok && pop) count_q <= count_q - CNT_W'(1);
      if (tile_valid && !push_ok) overflow <= 1'b1;
      xfer_done <= pop && out_last;
    end
  end

endmodule

// File: tb/tb_tile_fifo.sv
// Directed bench for tile_fifo: every step drives inputs 1 ns after a rising edge and checks outputs there.
module tb_tile_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [255:0] tile_in;
  logic         tile_valid;
  logic         tile_last;
  logic [255:0] out_tile;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         xfer_done;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  tile_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .tile_in(tile_in),
    .tile_valid(tile_valid), .tile_last(tile_last), .out_tile(out_tile),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_done(xfer_done), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic [7:0] base);
    logic [255:0] t;
    for (int i = 0; i < 32; i++) t[i*8 +: 8] = base + 8'(i);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] base, input logic last);
    tile_valid = 1'b1;
    tile_in    = mk(base);
    tile_last  = last;
    tick();
    tile_valid = 1'b0;
    tile_last  = 1'b0;
  endtask

  logic [7:0] q [$];
  logic [7:0] exp_base [5];
  logic       exp_last [5];
  int         pushed;
  int         pulses;
  int         guard;

  initial begin
    rst = 1'b0; flush = 1'b0; tile_in = '0; tile_valid = 1'b0;
    tile_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_empty", 256'(empty), 256'(1));
    chk("rst_full", 256'(full), 256'(0));
    chk("rst_out_tile", out_tile, 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_overflow", 256'(overflow), 256'(0));
    chk("rst_xfer_done", 256'(xfer_done), 256'(0));
    tick();
    rst = 1'b1;
    tick();

    // spurious last without valid
    tile_last = 1'b1;
    tick();
    tile_last = 1'b0;
    chk("spurious_last_count", 256'(count), 256'(0));

    // single tile with ready high
    out_ready = 1'b1;
    push(8'h00, 1'b1);
    chk("single_out_valid", 256'(out_valid), 256'(1));
    chk("single_out_tile", out_tile, mk(8'h00));
    chk("single_out_last", 256'(out_last), 256'(1));
    chk("single_xfer_early", 256'(xfer_done), 256'(0));
    tick();
    chk("single_xfer_done", 256'(xfer_done), 256'(1));
    chk("single_empty", 256'(empty), 256'(1));
    tick();
    chk("single_xfer_one_cycle", 256'(xfer_done), 256'(0));

    // fill to full, overflow, drain
    out_ready = 1'b0;
    push(8'h10, 1'b0);
    push(8'h20, 1'b0);
    push(8'h30, 1'b0);
    push(8'h40, 1'b0);
    chk("fill_count", 256'(count), 256'(4));
    chk("fill_full", 256'(full), 256'(1));
    chk("fill_overflow_clear", 256'(overflow), 256'(0));
    push(8'h50, 1'b0);
    chk("ovf_flag", 256'(overflow), 256'(1));
    chk("ovf_count", 256'(count), 256'(4));
    chk("ovf_head_kept", out_tile, mk(8'h10));
    out_ready = 1'b1;
    chk("drain_a", out_tile, mk(8'h10)); tick();
    chk("drain_b", out_tile, mk(8'h20)); tick();
    chk("drain_c", out_tile, mk(8'h30)); tick();
    chk("drain_d", out_tile, mk(8'h40)); tick();
    chk("drain_no_e", 256'(empty), 256'(1));
    chk("drain_ovf_sticky", 256'(overflow), 256'(1));
    out_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush1_overflow", 256'(overflow), 256'(0));

    // simultaneous push and pop while full
    push(8'h60, 1'b0);
    push(8'h70, 1'b0);
    push(8'h80, 1'b0);
    push(8'h90, 1'b0);
    out_ready = 1'b1;
    push(8'hA0, 1'b0);
    chk("pp_count", 256'(count), 256'(4));
    chk("pp_overflow", 256'(overflow), 256'(0));
    chk("pp_head_b", out_tile, mk(8'h70)); tick();
    chk("pp_head_c", out_tile, mk(8'h80)); tick();
    chk("pp_head_d", out_tile, mk(8'h90)); tick();
    chk("pp_head_f", out_tile, mk(8'hA0)); tick();
    chk("pp_empty", 256'(empty), 256'(1));
    out_ready = 1'b0;

    // wrap-around: bursts of up to 3 pushes then 2 pops
    pushed = 0;
    guard  = 0;
    while ((pushed < 10 || q.size() > 0) && guard < 20) begin
      guard++;
      for (int j = 0; j < 3; j++) begin
        if (pushed < 10 && q.size() < 4) begin
          q.push_back(8'hC0 + 8'(pushed * 3));
          push(8'hC0 + 8'(pushed * 3), 1'b0);
          pushed++;
          chk("wrap_count_push", 256'(count), 256'(q.size()));
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (q.size() > 0) begin
          out_ready = 1'b1;
          chk("wrap_head", out_tile, mk(q[0]));
          void'(q.pop_front());
          tick();
          out_ready = 1'b0;
          chk("wrap_count_pop", 256'(count), 256'(q.size()));
        end
      end
    end
    chk("wrap_finished", 256'(guard < 20), 256'(1));
    chk("wrap_empty", 256'(empty), 256'(1));

    // two transfers back to back: last flags 0,1 then 0,0,1
    exp_base = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    push(exp_base[0], exp_last[0]);
    push(exp_base[1], exp_last[1]);
    push(exp_base[2], exp_last[2]);
    push(exp_base[3], exp_last[3]);
    out_ready = 1'b1;
    chk("bb_head_0", out_tile, mk(exp_base[0]));
    chk("bb_last_0", 256'(out_last), 256'(exp_last[0]));
    push(exp_base[4], exp_last[4]);
    chk("bb_count_full", 256'(count), 256'(4));
    pulses = 0;
    if (xfer_done) pulses++;
    chk("bb_xfer_0", 256'(xfer_done), 256'(exp_last[0]));
    for (int k = 1; k < 5; k++) begin
      chk("bb_head", out_tile, mk(exp_base[k]));
      chk("bb_last", 256'(out_last), 256'(exp_last[k]));
      tick();
      if (xfer_done) pulses++;
      chk("bb_xfer", 256'(xfer_done), 256'(exp_last[k]));
    end
    tick();
    chk("bb_xfer_after", 256'(xfer_done), 256'(0));
    chk("bb_pulses", 256'(pulses), 256'(2));
    chk("bb_empty", 256'(empty), 256'(1));
    out_ready = 1'b0;

    // flush with count 3 and overflow set, competing with a push
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b0);
    push(8'h55, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pre_flush_count", 256'(count), 256'(3));
    chk("pre_flush_ovf", 256'(overflow), 256'(1));
    flush = 1'b1;
    push(8'h66, 1'b1);
    flush = 1'b0;
    chk("flush_count", 256'(count), 256'(0));
    chk("flush_empty", 256'(empty), 256'(1));
    chk("flush_overflow", 256'(overflow), 256'(0));
    chk("flush_xfer", 256'(xfer_done), 256'(0));

    // async reset mid-stream with a last-flagged head about to be popped
    push(8'h77, 1'b1);
    chk("prerst_count", 256'(count), 256'(1));
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_count", 256'(count), 256'(0));
    chk("arst_empty", 256'(empty), 256'(1));
    chk("arst_out_tile", out_tile, 256'(0));
    chk("arst_out_last", 256'(out_last), 256'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("postrst_xfer", 256'(xfer_done), 256'(0));
    chk("postrst_empty", 256'(empty), 256'(1));
    tick();
    chk("postrst_xfer2", 256'(xfer_done), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_fifo.md
Name: tile_fifo

Overview:
- Tile buffer directly downstream of the vector loader.
- Captures each tile the loader presents (tile pulse plus array data) and marks the final tile of a transfer (loader done pulse).
- Holds up to DEPTH tiles in a circular buffer.
- Presents them in order to the compute/buffer-file stage with a valid/ready handshake, decoupling DRAM fetch from compute stalls.

Parameters:
- TILE_WIDTH, 256: bits per tile.
- DATA_WIDTH, 8: bits per element; ELEM_COUNT = TILE_WIDTH/DATA_WIDTH = 32.
- DEPTH, 4: tile slots; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous clear of all contents; active-high.
- tile_in  input  DATA_WIDTH x ELEM_COUNT  incoming tile elements, index 0..ELEM_COUNT-1.
- tile_valid  input  1  one-cycle push pulse; loader tile_out.
- tile_last  input  1  sampled with tile_valid; loader valid_out, which coincides with its final tile_out.
- out_tile  output  DATA_WIDTH x ELEM_COUNT  head tile elements.
- out_last  output  1  head tile carries the last flag.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts the head.
- xfer_done  output  1  one-cycle pulse when a last-flagged tile is popped.
- count  output  $clog2(DEPTH+1)  occupied slots.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky error; push was dropped.

Behaviour:
- Reset (rst low, async):
  - wr_ptr, rd_ptr and count are 0.
  - overflow = 0, xfer_done = 0.
  - All slot storage and last flags are cleared to 0.
  - Resulting outputs: out_valid = 0, empty = 1, full = 0, out_tile all zero, out_last = 0.
  - Reset mid-stream discards all contents with no xfer_done.
- Storage and pointers:
  - DEPTH slots of ELEM_COUNT x DATA_WIDTH, plus a 1-bit last flag per slot.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Head presentation:
  - Show-ahead: out_tile and out_last are combinational from slot[rd_ptr].
  - out_valid = !empty; empty and full decode from count.
- Pop: pop = out_valid && out_ready. On pop, rd_ptr increments by one.
- Push acceptance:
  - push_ok = tile_valid && (!full || pop).
  - On push_ok, slot[wr_ptr] <= tile_in and flag[wr_ptr] <= tile_last, then wr_ptr increments.
  - The written data is visible at the head at the earliest on the next cycle (count 0 -> out_valid rises one cycle after the tile_valid cycle).
- Count update: count += push_ok - pop. A simultaneous push and pop leaves count unchanged, including when full.
- Overflow:
  - tile_valid while full and no pop drops the tile; nothing is written and no pointer moves.
  - overflow is then set to 1 and held until reset or flush.
- Spurious last: tile_last without tile_valid is ignored.
- xfer_done:
  - Registered: set to 1 the cycle after a pop whose out_last = 1, otherwise 0.
  - Consecutive last-flagged pops give consecutive pulses.
- Flush:
  - Synchronous; takes precedence over push and pop in the same cycle.
  - Pointers, count and overflow are cleared to 0; xfer_done is 0 on the next cycle.
  - Storage need not be cleared.
- Back-to-back operation: a new transfer's tiles may be pushed while the previous transfer's tiles are still queued. Ordering is strictly FIFO and per-tile last flags keep transfers separated.
- Consumer hold-off: out_ready held low means the head remains stable (out_tile, out_last unchanged) until popped.

Test Plan:
- Single tile, ready=1: push tile 0x00..0x1F with last=1 at cycle 0 -> out_valid=1 at cycle 1 with out_tile[i]=i and out_last=1; pop at cycle 1; xfer_done=1 at cycle 2; empty=1 at cycle 2.
- Fill to full, ready=0: 4 pushes with element-0 values A,B,C,D -> count=4, full=1. Fifth push E -> overflow=1, count stays 4. Then ready=1 -> pops A,B,C,D in order and E never appears.
- Simultaneous push/pop at full: full, ready=1 and push F in the same cycle -> count stays 4, overflow=0, and F appears as head after the 4 prior entries drain.
- Wrap-around: 10 tiles pushed and popped in an interleaved pattern, 3 in then 2 out repeatedly -> output sequence exactly matches input order across pointer wrap; count never exceeds 4.
- Two transfers back-to-back: 2 tiles (second last=1) then 3 tiles (third last=1), consumer stalled then drained -> xfer_done pulses exactly twice, the cycles after the 2nd and 5th pops.
- Flush and async reset: flush with count=3 and overflow=1 -> next cycle count=0, empty=1, overflow=0. Assert rst low mid-stream between clock edges -> outputs go to reset values immediately, and no xfer_done fires after rst releases.
